puzzle_tx: RTL and testbench
============================

PUZZLE_TX -- requirements
Module: puzzle_tx

Interface
REQ-001 Parameter HEIGHT, default 10, grid rows.
REQ-002 Parameter WIDTH, default 10, grid columns.
REQ-003 Parameter MOVE_DEPTH, default 16, move FIFO entries (power of two).
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 wr_en / wr_addr / wr_data  in  1/7/8  grid cell write; addr = WIDTH*row + col.
REQ-007 start_x, start_y, goal_x, goal_y  in  8 each  header values, sampled on start.
REQ-008 start  in  1  begin one transfer.
REQ-009 mv_valid / mv_dir / mv_last  in  1/2/1  move push; dir 0=N, 1=S, 2=E, 3=W; last marks final move.
REQ-010 mv_ready  out  1  high when FIFO not full.
REQ-011 grid_input  out  8  byte to puzzle receiver.
REQ-012 enable / enable_process / puzzle_rst  out  1 each  receiver load strobe, move strobe, receiver clear.
REQ-013 busy / done  out  1 each  transfer in progress, one-cycle completion pulse.

Function
REQ-014 FSM states: IDLE, CLEAR, HDR, GRID, MOVE, DONE; all stream outputs registered.
REQ-015 IDLE: wr_en writes grid RAM; start moves the FSM to CLEAR and latches the header.
REQ-016 CLEAR, 1 cycle: enable=1, puzzle_rst=1, grid_input=0.
REQ-017 HDR, 4 cycles: enable=1; bytes start_x, start_y, goal_x, goal_y in that order.
REQ-018 GRID, HEIGHT*WIDTH cycles: enable=1; cells in row-major order, addr 0 first.
REQ-019 Latency: start accepted at cycle T gives CLEAR at T+1, header at T+2..T+5, grid at T+6..T+105, earliest move at T+106.
REQ-020 MOVE, FIFO non-empty: pop one entry per cycle; emit enable=0, enable_process=1, grid_input = 78/83/69/87 for N/S/E/W.
REQ-021 MOVE, FIFO empty: hold enable_process=0 and grid_input=0; never emit a non-move byte with enable_process=1.
REQ-022 Popping the entry with mv_last=1 moves the FSM to DONE; DONE lasts 1 cycle with done=1, then returns to IDLE.
REQ-023 busy=1 in all states except IDLE.
REQ-024 FIFO push occurs when mv_valid && mv_ready, in any state.
REQ-025 Full FIFO gives mv_ready=0; a push and a pop in the same cycle when full is not accepted.
REQ-026 Pointers wrap modulo MOVE_DEPTH; a separate count distinguishes full from empty.
REQ-027 In every state other than IDLE, wr_en and start are ignored.
REQ-028 In every state other than IDLE, the header registers do not change.
REQ-029 Grid RAM data wraps naturally at 8 bits; no range checks are made on the header values.

Reset
REQ-030 rst=1 forces IDLE and empties the FIFO by the next edge.
REQ-031 rst=1 clears all outputs to 0 by the next edge: grid_input, enable, enable_process, puzzle_rst, busy, done.
REQ-032 On reset, mv_ready=1 from the first cycle after rst.
REQ-033 Reset mid-transfer aborts the transfer at once; no further bytes are emitted.
REQ-034 Grid RAM contents are not reset and persist across rst.

Configuration
REQ-035 Macro PUZZLE_TX_TRACK_EN: when defined, add output err (1 bit) and track position from the latched start_x/start_y, updated on each emitted move (N: y-1, S: y+1, E: x+1, W: x-1).
REQ-036 With the macro defined, err is set sticky when an emitted move leaves 0..WIDTH-1 / 0..HEIGHT-1; err is cleared by rst or start; the stream itself is unchanged.
REQ-037 Without the macro: no err port and no tracking logic.

Structure
REQ-038 Shared package puzzle_pkg holds the direction encoding and the ASCII constants N=78, S=83, E=69, W=87.
REQ-039 puzzle_pkg also holds the FSM state enum and the default HEIGHT/WIDTH.
REQ-040 One sub-module, puzzle_move_fifo: synchronous FIFO, 3-bit entries {last, dir}.

Verification
REQ-041 Write cells addr k = k%7; start with header (1,2,3,4); preload moves E,S(last).
  -> puzzle_rst pulse at T+1; header bytes 1,2,3,4 at T+2..T+5; grid at T+6..T+105 with byte k = k%7.
  -> E (69) at T+106, S (83) at T+107; done pulse at T+108.
REQ-042 Start with an empty FIFO; push N (last) 5 cycles after GRID ends -> enable_process=0 for the gap, then 78 is emitted, then done.
REQ-043 Push 17 moves with no start -> mv_ready=0 after 16 pushes; the 17th is not accepted; order is preserved on drain.
REQ-044 Assert rst at T+50 -> all outputs 0 at T+51; FIFO empty; a new start replays the unchanged grid.
REQ-045 start and wr_en during GRID -> no restart and grid RAM unchanged.
REQ-046 With PUZZLE_TX_TRACK_EN, start (0,0), move N -> err=1; a following start clears err.

Source files
------------

// File: rtl/puzzle_pkg.sv
// Shared encodings for the puzzle transmitter: move directions, ASCII move
// bytes, FSM state codes, default grid size and the move FIFO entry layout.
package puzzle_pkg;

    localparam int DEF_HEIGHT = 10;
    localparam int DEF_WIDTH  = 10;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_S = 2'd1,
        DIR_E = 2'd2,
        DIR_W = 2'd3
    } dir_e;

    localparam logic [7:0] ASCII_N = 8'd78;
    localparam logic [7:0] ASCII_S = 8'd83;
    localparam logic [7:0] ASCII_E = 8'd69;
    localparam logic [7:0] ASCII_W = 8'd87;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CLEAR = 3'd1;
    localparam state_t ST_HDR   = 3'd2;
    localparam state_t ST_GRID  = 3'd3;
    localparam state_t ST_MOVE  = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    typedef struct packed {
        logic last;
        dir_e dir;
    } move_t;

    function automatic logic [7:0] dir_ascii(input dir_e d);
        case (d)
            DIR_N:   return ASCII_N;
            DIR_S:   return ASCII_S;
            DIR_E:   return ASCII_E;
            default: return ASCII_W;
        endcase
    endfunction

endpackage

// File: rtl/puzzle_move_fifo.sv
// Synchronous FIFO of {last, dir} move entries. A separate occupancy count
// tells full from empty since the pointers wrap modulo DEPTH.
module puzzle_move_fifo
    import puzzle_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  move_t din,
    input  logic  pop,
    output move_t dout,
    output logic  full,
    output logic  empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    move_t         mem [0:DEPTH-1];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          do_push, do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    // A push into a full FIFO is dropped even when a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/puzzle_tx.sv
// Streams clear, header, grid and queued moves to a puzzle receiver.
// Optional macro PUZZLE_TX_TRACK_EN adds position tracking with a sticky err.
module puzzle_tx
    import puzzle_pkg::*;
#(
    parameter int HEIGHT     = DEF_HEIGHT,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int MOVE_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [6:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [7:0] start_x,
    input  logic [7:0] start_y,
    input  logic [7:0] goal_x,
    input  logic [7:0] goal_y,
    input  logic       start,
    input  logic       mv_valid,
    input  logic [1:0] mv_dir,
    input  logic       mv_last,
    output logic       mv_ready,
    output logic [7:0] grid_input,
    output logic       enable,
    output logic       enable_process,
    output logic       puzzle_rst,
    output logic       busy,
    output logic       done
`ifdef PUZZLE_TX_TRACK_EN
    ,
    output logic       err
`endif
);

    localparam int CELLS = HEIGHT * WIDTH;
    localparam int AW    = (CELLS > 4) ? $clog2(CELLS) : 2;
    localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);

    logic [7:0]      ram [0:(2**AW)-1];
    logic [3:0][7:0] hdr_q;
    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            fin_q, fin_d;
    logic [7:0]      byte_d;
    logic            en_d, ep_d, prst_d, done_d, move_slot;
    logic            push, pop, fifo_full, fifo_empty;
    move_t           push_ent, head;

    assign push_ent = '{last: mv_last, dir: dir_e'(mv_dir)};
    assign push     = mv_valid && !fifo_full;
    assign mv_ready = !fifo_full;

    puzzle_move_fifo #(.DEPTH(MOVE_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_ent),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && wr_en && int'(wr_addr) < CELLS)
            ram[AW'(wr_addr)] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && start)
            hdr_q <= {goal_y, goal_x, start_y, start_x};
    end

    // Next-state and next-output logic; outputs are registered alongside the
    // state so the stream byte and the state register always describe the same cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fin_d     = fin_q;
        byte_d    = '0;
        en_d      = 1'b0;
        ep_d      = 1'b0;
        prst_d    = 1'b0;
        done_d    = 1'b0;
        pop       = 1'b0;
        move_slot = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_CLEAR;
                en_d    = 1'b1;
                prst_d  = 1'b1;
            end
            ST_CLEAR: begin
                state_d = ST_HDR;
                cnt_d   = '0;
                en_d    = 1'b1;
                byte_d  = hdr_q[0];
            end
            ST_HDR: begin
                en_d = 1'b1;
                if (cnt_q == AW'(3)) begin
                    state_d = ST_GRID;
                    cnt_d   = '0;
                    byte_d  = ram[AW'(0)];
                end else begin
                    cnt_d  = cnt_q + AW'(1);
                    byte_d = hdr_q[cnt_q[1:0] + 2'd1];
                end
            end
            ST_GRID: begin
                if (cnt_q == LAST_CELL) begin
                    move_slot = 1'b1;
                end else begin
                    en_d   = 1'b1;
                    cnt_d  = cnt_q + AW'(1);
                    byte_d = ram[cnt_q + AW'(1)];
                end
            end
            ST_MOVE: move_slot = 1'b1;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // fin_q marks that the last move is on the wire; the following cycle is DONE.
        if (move_slot) begin
            state_d = ST_MOVE;
            if (fin_q) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                fin_d   = 1'b0;
            end else if (!fifo_empty) begin
                pop    = 1'b1;
                ep_d   = 1'b1;
                byte_d = dir_ascii(head.dir);
                fin_d  = head.last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            fin_q          <= 1'b0;
            grid_input     <= '0;
            enable         <= 1'b0;
            enable_process <= 1'b0;
            puzzle_rst     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            fin_q          <= fin_d;
            grid_input     <= byte_d;
            enable         <= en_d;
            enable_process <= ep_d;
            puzzle_rst     <= prst_d;
            busy           <= (state_d != ST_IDLE);
            done           <= done_d;
        end
    end

`ifdef PUZZLE_TX_TRACK_EN
    localparam logic signed [9:0] XMAX = 10'(WIDTH - 1);
    localparam logic signed [9:0] YMAX = 10'(HEIGHT - 1);

    logic signed [9:0] pos_x, pos_y, nx, ny;

    always_comb begin
        nx = pos_x;
        ny = pos_y;
        case (head.dir)
            DIR_N: ny = pos_y - 10'sd1;
            DIR_S: ny = pos_y + 10'sd1;
            DIR_E: nx = pos_x + 10'sd1;
            DIR_W: nx = pos_x - 10'sd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_x <= '0;
            pos_y <= '0;
            err   <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            pos_x <= $signed({2'b00, start_x});
            pos_y <= $signed({2'b00, start_y});
            err   <= 1'b0;
        end else if (pop) begin
            pos_x <= nx;
            pos_y <= ny;
            if (nx < 10'sd0 || nx > XMAX || ny < 10'sd0 || ny > YMAX)
                err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_puzzle_tx.sv
// Scoreboard bench for puzzle_tx: expected per-cycle output vectors are queued
// when a transfer is launched and compared at each negedge.
module tb_puzzle_tx;
    import puzzle_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0, start = 1'b0, mv_valid = 1'b0, mv_last = 1'b0;
    logic [6:0] wr_addr = '0;
    logic [7:0] wr_data = '0, start_x = '0, start_y = '0, goal_x = '0, goal_y = '0;
    logic [1:0] mv_dir = '0;
    logic       mv_ready, enable, enable_process, puzzle_rst, busy, done;
    logic [7:0] grid_input;
`ifdef PUZZLE_TX_TRACK_EN
    logic       err;
`endif

    typedef struct packed {
        logic       en;
        logic       ep;
        logic       prst;
        logic       bz;
        logic       dn;
        logic [7:0] b;
    } vec_t;

    vec_t       exp_q[$];
    logic [7:0] gmodel [0:99];
    int         n_vec = 0, n_miss = 0;

    puzzle_tx dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start_x(start_x), .start_y(start_y), .goal_x(goal_x), .goal_y(goal_y),
        .start(start), .mv_valid(mv_valid), .mv_dir(mv_dir), .mv_last(mv_last),
        .mv_ready(mv_ready), .grid_input(grid_input), .enable(enable),
        .enable_process(enable_process), .puzzle_rst(puzzle_rst), .busy(busy),
        .done(done)
`ifdef PUZZLE_TX_TRACK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic vec_t obs();
        return vec_t'({enable, enable_process, puzzle_rst, busy, done, grid_input});
    endfunction

    function automatic vec_t mk(input logic en, input logic ep, input logic prst,
                                input logic bz, input logic dn, input logic [7:0] b);
        vec_t v;
        v.en = en; v.ep = ep; v.prst = prst; v.bz = bz; v.dn = dn; v.b = b;
        return v;
    endfunction

    function automatic logic [7:0] ascii(input int d);
        case (d)
            0:       return 8'd78;
            1:       return 8'd83;
            2:       return 8'd69;
            default: return 8'd87;
        endcase
    endfunction

    function automatic void exp_stream(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
        exp_q.push_back(mk(1, 0, 1, 1, 0, 8'h00));
        exp_q.push_back(mk(1, 0, 0, 1, 0, a));
        exp_q.push_back(mk(1, 0, 0, 1, 0, b));
        exp_q.push_back(mk(1, 0, 0, 1, 0, c));
        exp_q.push_back(mk(1, 0, 0, 1, 0, d));
        for (int k = 0; k < 100; k++) exp_q.push_back(mk(1, 0, 0, 1, 0, gmodel[k]));
    endfunction

    function automatic void exp_move(input int d);
        exp_q.push_back(mk(0, 1, 0, 1, 0, ascii(d)));
    endfunction

    function automatic void exp_tail();
        exp_q.push_back(mk(0, 0, 0, 1, 1, 8'h00));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 8'h00));
    endfunction

    task automatic write_cell(input int a, input logic [7:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = 7'(a); wr_data = d;
    endtask

    task automatic push_idle(input int d, input logic last);
        @(posedge clk); #1;
        mv_valid = 1'b1; mv_dir = 2'(d); mv_last = last;
        @(posedge clk); #1;
        mv_valid = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        @(posedge clk); #1;
        start = 1'b1; start_x = a; start_y = b; goal_x = c; goal_y = d;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        vec_t got;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        got = obs();
        n_vec++;
        if (got !== vec_t'(0)) begin
            n_miss++; $display("FAIL reset_outputs: got %h want 0", got);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        got = obs();
        n_vec++;
        if (got !== vec_t'(0)) begin
            n_miss++; $display("FAIL post_reset_outputs: got %h want 0", got);
        end
        n_vec++;
        if (mv_ready !== 1'b1) begin
            n_miss++; $display("FAIL post_reset_mv_ready: got %b want 1", mv_ready);
        end
    endtask

    task automatic test_basic();
        vec_t got, want;
        for (int k = 0; k < 100; k++) begin
            gmodel[k] = 8'(k % 7);
            write_cell(k, gmodel[k]);
        end
        @(posedge clk); #1 wr_en = 1'b0;
        push_idle(2, 1'b0);
        push_idle(1, 1'b1);
        do_start(8'd1, 8'd2, 8'd3, 8'd4);
        exp_stream(8'd1, 8'd2, 8'd3, 8'd4);
        exp_move(2);
        exp_move(1);
        exp_tail();
        while (exp_q.size() > 0) begin
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++; $display("FAIL basic_stream: got %h want %h", got, want);
            end
        end
    endtask

    task automatic test_gap();
        vec_t got, want;
        do_start(8'd8, 8'd7, 8'd6, 8'd5);
        exp_stream(8'd8, 8'd7, 8'd6, 8'd5);
        repeat (6) exp_q.push_back(mk(0, 0, 0, 1, 0, 8'h00));
        exp_move(0);
        exp_tail();
        for (int i = 0; i < 110; i++) begin
            if (i == 109) begin
                @(posedge clk); #1;
                mv_valid = 1'b1; mv_dir = 2'd0; mv_last = 1'b1;
            end
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++; $display("FAIL gap_stream[%0d]: got %h want %h", i, got, want);
            end
        end
        @(posedge clk); #1 mv_valid = 1'b0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++; $display("FAIL gap_tail: got %h want %h", got, want);
            end
        end
    endtask

    task automatic test_fifo_full();
        vec_t got, want;
        int   stored;
        stored = 0;
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
            mv_valid = 1'b1;
            mv_dir   = (i == 16) ? 2'd1 : 2'(i % 4);
            mv_last  = (i >= 15);
            @(negedge clk);
            n_vec++;
            if (mv_ready !== (stored < 16)) begin
                n_miss++; $display("FAIL full_ready[%0d]: got %b want %b", i, mv_ready, stored < 16);
            end
            if (stored < 16) stored++;
        end
        @(posedge clk); #1 mv_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (mv_ready !== 1'b0) begin
            n_miss++; $display("FAIL full_ready_hold: got %b want 0", mv_ready);
        end
        do_start(8'd9, 8'd9, 8'd9, 8'd9);
        exp_stream(8'd9, 8'd9, 8'd9, 8'd9);
        for (int i = 0; i < 16; i++) exp_move(i % 4);
        exp_tail();
        while (exp_q.size() > 0) begin
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++; $display("FAIL full_drain: got %h want %h", got, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        vec_t got, want;
        push_idle(3, 1'b1);
        do_start(8'd5, 8'd6, 8'd7, 8'd8);
        exp_stream(8'd5, 8'd6, 8'd7, 8'd8);
        while (exp_q.size() > 50) void'(exp_q.pop_back());
        exp_q.push_back(mk(0, 0, 0, 0, 0, 8'h00));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 8'h00));
        for (int i = 0; i < 52; i++) begin
            if (i == 49) begin @(posedge clk); #1 rst = 1'b1; end
            if (i == 50) begin @(posedge clk); #1 rst = 1'b0; end
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++; $display("FAIL rst_mid[%0d]: got %h want %h", i, got, want);
            end
        end
        // Restart: grid must replay unchanged and the pre-reset W must be gone.
        do_start(8'd1, 8'd1, 8'd1, 8'd1);
        exp_stream(8'd1, 8'd1, 8'd1, 8'd1);
        repeat (2) exp_q.push_back(mk(0, 0, 0, 1, 0, 8'h00));
        exp_move(1);
        exp_tail();
        for (int i = 0; i < 106; i++) begin
            if (i == 105) begin
                @(posedge clk); #1;
                mv_valid = 1'b1; mv_dir = 2'd1; mv_last = 1'b1;
            end
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++; $display("FAIL rst_replay[%0d]: got %h want %h", i, got, want);
            end
        end
        @(posedge clk); #1 mv_valid = 1'b0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++; $display("FAIL rst_replay_tail: got %h want %h", got, want);
            end
        end
    endtask

    task automatic test_grid_lock();
        vec_t got, want;
        gmodel[99] = 8'hFF;
        write_cell(99, 8'hFF);
        @(posedge clk); #1 wr_en = 1'b0;
        push_idle(2, 1'b1);
        do_start(8'd200, 8'd255, 8'd0, 8'd17);
        exp_stream(8'd200, 8'd255, 8'd0, 8'd17);
        exp_move(2);
        exp_tail();
        for (int i = 0; i < 20; i++) begin
            if (i == 19) begin
                @(posedge clk); #1;
                start = 1'b1; wr_en = 1'b1; wr_addr = 7'd50; wr_data = 8'hAA; start_x = 8'd9;
            end
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++; $display("FAIL lock_stream[%0d]: got %h want %h", i, got, want);
            end
        end
        @(posedge clk); #1 start = 1'b0; wr_en = 1'b0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++; $display("FAIL lock_tail: got %h want %h", got, want);
            end
        end
    endtask

`ifdef PUZZLE_TX_TRACK_EN
    task automatic test_track();
        vec_t got, want;
        push_idle(0, 1'b1);
        do_start(8'd0, 8'd0, 8'd3, 8'd3);
        exp_stream(8'd0, 8'd0, 8'd3, 8'd3);
        exp_move(0);
        exp_tail();
        while (exp_q.size() > 0) begin
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++; $display("FAIL track_stream: got %h want %h", got, want);
            end
        end
        n_vec++;
        if (err !== 1'b1) begin
            n_miss++; $display("FAIL track_err_set: got %b want 1", err);
        end
        do_start(8'd4, 8'd4, 8'd0, 8'd0);
        @(negedge clk);
        n_vec++;
        if (err !== 1'b0) begin
            n_miss++; $display("FAIL track_err_clear: got %b want 0", err);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_fifo_full();
        test_reset_mid();
        test_grid_lock();
`ifdef PUZZLE_TX_TRACK_EN
        test_track();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
